// File: rtl/muldiv_sched.sv
// muldiv_sched: issue and hazard controller for the shared multiply/divide unit.
// Decides when a mult/div/HI-LO instruction in E may use the unit, pulses the
// unit's start, masks the op code to the harmless mflo (111) whenever the E
// instruction is not actually going, stalls while an operation is in flight,
// and counts stall cycles for performance debug.
module muldiv_sched #(
    parameter int unsigned MULT_LAT = 5,  // 1..15, >= unit mult busy time
    parameter int unsigned DIV_LAT  = 10  // 1..15, >= unit div busy time
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic        e_flush,
    input  logic        md_busy,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic        md_stall,
    output logic        md_inflight,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);
    localparam logic [2:0] OP_MFLO  = 3'b111;

    state_t     state;
    logic [3:0] cnt;

    logic start_op;
    logic hazard;
    logic go;

    // Issue decision and unit-facing outputs, purely from state and E inputs.
    always_comb begin
        start_op = ~e_op[2];
        hazard   = (state == RUN) | md_busy;
        go       = e_valid & ~e_flush & ~hazard;
        md_stall = e_valid & ~e_flush & hazard;
        md_start = go & start_op;
        // mflo has no side effects, so it is the safe code on any non-go cycle.
        md_op    = go ? e_op : OP_MFLO;
    end

    // Issue FSM with occupancy down-counter, in-flight flag and stall counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            md_inflight <= 1'b0;
            stall_cnt   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        state       <= RUN;
                        cnt         <= e_op[1] ? DIV_CNT : MULT_CNT;
                        md_inflight <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        state       <= IDLE;
                        cnt         <= 4'd0;
                        md_inflight <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= 4'd0;
                    md_inflight <= 1'b0;
                end
            endcase
            // Free-running wrap from all-ones back to zero is intended.
            if (md_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: scoreboard bench for muldiv_sched. The driver issues one
// E-stage input set per cycle and pushes the reference model's expectation;
// a separate monitor pops and compares on the falling edge. The model tracks
// the unit reservation as "free from cycle N" rather than a state machine.
module tb_muldiv_sched;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [2:0]  e_op;
    logic        e_flush;
    logic        md_busy;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_stall;
    logic        md_inflight;
    logic [31:0] stall_cnt;

    muldiv_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_op        (e_op),
        .e_flush     (e_flush),
        .md_busy     (md_busy),
        .md_start    (md_start),
        .md_op       (md_op),
        .md_stall    (md_stall),
        .md_inflight (md_inflight),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic [2:0]  op;
        logic        stall;
        logic        inflight;
        logic [31:0] scnt;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: current cycle number, first cycle the unit is
    // free again, and the running stall count.
    int          m_cyc  = 0;
    int          m_free = 0;
    logic [31:0] m_scnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; wrap preloads the stall counter via force.
    task automatic cycle(input logic v, input logic [2:0] op, input logic fl,
                         input logic busy, input logic rst, input logic wrap);
        exp_t e;
        logic run_now, hz, go_now;
        @(posedge clk);
        #1;
        if (wrap) begin
            force dut.stall_cnt = 32'hFFFF_FFFF;
            #1;
            release dut.stall_cnt;
            m_scnt = 32'hFFFF_FFFF;
        end
        e_valid = v;
        e_op    = op;
        e_flush = fl;
        md_busy = busy;
        reset   = rst;

        run_now    = (m_cyc < m_free);
        hz         = run_now | busy;
        go_now     = v & ~fl & ~hz;
        e.start    = go_now & (op < 3'd4);
        e.op       = go_now ? op : 3'b111;
        e.stall    = v & ~fl & hz;
        e.inflight = run_now;
        e.scnt     = m_scnt;
        sbq.push_back(e);

        if (rst) begin
            m_free = m_cyc + 1;
            m_scnt = 32'd0;
        end else begin
            if (e.start) m_free = m_cyc + 1 + int'(op[1] ? DIV_LAT : MULT_LAT);
            if (e.stall) m_scnt = m_scnt + 32'd1;
        end
        m_cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic rst);
        cycle(1'b0, 3'b000, 1'b0, 1'b0, rst, 1'b0);
    endtask

    // Monitor: compare DUT outputs against each pushed expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_md_start",    32'(md_start),    32'(e.start));
                check("sb_md_op",       32'(md_op),       32'(e.op));
                check("sb_md_stall",    32'(md_stall),    32'(e.stall));
                check("sb_md_inflight", 32'(md_inflight), 32'(e.inflight));
                check("sb_stall_cnt",   stall_cnt,        e.scnt);
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        e_valid = 1'b0;
        e_op    = 3'b000;
        e_flush = 1'b0;
        md_busy = 1'b0;

        // Reset state with idle inputs.
        idle(1'b1);
        idle(1'b0);
        settle();
        check("rst_md_start",    32'(md_start),    32'd0);
        check("rst_md_stall",    32'(md_stall),    32'd0);
        check("rst_md_op",       32'(md_op),       32'd7);
        check("rst_md_inflight", 32'(md_inflight), 32'd0);
        check("rst_stall_cnt",   stall_cnt,        32'd0);

        // mult then mfhi.
        idle(1'b1);
        cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("mult_start", 32'(md_start), 32'd1);
        check("mult_op",    32'(md_op),    32'd0);
        check("mult_nostall", 32'(md_stall), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
            settle();
            check("mfhi_stall", 32'(md_stall), 32'd1);
            check("mfhi_inflight", 32'(md_inflight), 32'd1);
        end
        cycle(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("mfhi_release", 32'(md_stall), 32'd0);
        check("mfhi_op",      32'(md_op),    32'd6);
        check("mfhi_cnt",     stall_cnt,     32'd5);

        // divu then mflo.
        idle(1'b1);
        cycle(1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("divu_start", 32'(md_start), 32'd1);
        check("divu_op",    32'(md_op),    32'd3);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
            settle();
            check("mflo_stall", 32'(md_stall), 32'd1);
        end
        cycle(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("mflo_release", 32'(md_stall), 32'd0);
        check("mflo_cnt",     stall_cnt,     32'd10);

        // mthi while RUN: no HI write until RUN ends, then exactly one cycle.
        idle(1'b1);
        cycle(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
            settle();
            check("mthi_held_op", 32'(md_op), 32'd7);
        end
        cycle(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("mthi_go_op", 32'(md_op), 32'd4);
        check("mthi_no_start", 32'(md_start), 32'd0);
        idle(1'b0);
        settle();
        check("mthi_after_op", 32'(md_op), 32'd7);
        check("mthi_stays_idle", 32'(md_inflight), 32'd0);

        // Flush on a would-be div start.
        idle(1'b1);
        cycle(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("flush_start", 32'(md_start), 32'd0);
        check("flush_op",    32'(md_op),    32'd7);
        check("flush_stall", 32'(md_stall), 32'd0);
        cycle(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("flush_idle",    32'(md_inflight), 32'd0);
        check("flush_nostall", 32'(md_stall),    32'd0);
        check("flush_cnt",     stall_cnt,        32'd0);

        // Flush while RUN does not abort; e_valid=0 never stalls.
        cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("runflush_nostall", 32'(md_stall),    32'd0);
        check("runflush_inflight", 32'(md_inflight), 32'd1);
        cycle(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("novalid_nostall", 32'(md_stall), 32'd0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        // Back-to-back: accepted the first cycle after RUN exits.
        cycle(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("b2b_start", 32'(md_start), 32'd1);

        // reset mid-RUN with md_busy held until cycle 4.
        idle(1'b1);
        cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("rstrun_inflight", 32'(md_inflight), 32'd0);
        check("rstrun_cnt",      stall_cnt,        32'd0);
        check("rstrun_start",    32'(md_start),    32'd0);
        check("rstrun_stall",    32'(md_stall),    32'd1);
        cycle(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("rstrun_release", 32'(md_stall), 32'd0);
        check("rstrun_cnt2",    stall_cnt,     32'd1);

        // stall_cnt wrap from all-ones.
        idle(1'b1);
        cycle(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check("wrap_pre", stall_cnt, 32'hFFFF_FFFF);
        cycle(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("wrap_post", stall_cnt, 32'h0000_0000);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            logic v, fl, b, r;
            logic [2:0] op;
            v  = ($urandom_range(99) < 70);
            op = 3'($urandom_range(7));
            fl = ($urandom_range(99) < 10);
            b  = ($urandom_range(99) < 15);
            r  = ($urandom_range(99) < 2);
            cycle(v, op, fl, b, r, 1'b0);
        end

        idle(1'b0);
        settle();
        @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Issue and hazard controller for the shared multiply/divide unit in the execute stage. It decides when a mult/div/HI-LO instruction in E may use the unit, pulses the unit's start, gates the op code so that HI/LO writes occur only for committed instructions, and stalls the pipeline while an operation is in flight. It also counts stall cycles for performance debug.

## Interface
- `MULT_LAT`, default 5: cycles the unit is unavailable after a mult/multu start; must be ≥ the unit's mult busy time, range 1..15.
- `DIV_LAT`, default 10: the same for div/divu, range 1..15.
- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: synchronous, active-high.
- `e_valid` in 1: E stage holds a multiply/divide-class instruction.
- `e_op` in 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo.
- `e_flush` in 1: E instruction is being killed this cycle.
- `md_busy` in 1: busy flag from the unit.
- `md_start` out 1: start pulse to the unit.
- `md_op` out 3: op code to the unit.
- `md_stall` out 1: hold F/D/E and bubble M.
- `md_inflight` out 1: state is RUN.
- `stall_cnt` out 32: number of cycles with `md_stall`=1 since reset.

## Operation
- States are IDLE and RUN. There is a 4-bit down-counter `cnt`.
- `start_op` = `e_op[2:1]`==00 or 01, i.e. codes 000..011.
- `hazard` = (state==RUN) | `md_busy`.
- `md_stall` = `e_valid` & ~`e_flush` & `hazard`. Every op code stalls on a hazard, including mfhi/mflo/mthi/mtlo.
- `go` = `e_valid` & ~`e_flush` & ~`hazard`.
- `md_start` = `go` & `start_op`.
- `md_op` = `e_op` when `go`, else 111. 111 is the side-effect-free read of LO, so no stray HI/LO write occurs on a stall, flush or idle cycle.
- IDLE to RUN when `md_start`=1. Load `cnt` with `MULT_LAT` for 00x codes and `DIV_LAT` for 01x codes.
- In RUN, `cnt` decrements each cycle. When `cnt`==1, go to IDLE with `cnt` set to 0.
- mthi/mtlo/mfhi/mflo never leave IDLE. They are single-cycle passes with `md_op`=`e_op`.
- `md_busy` alone never changes state. It only extends `hazard`.
- `stall_cnt` increments when `md_stall`=1 and wraps from 0xFFFFFFFF to 0.
- All outputs are combinational from state plus inputs, except `stall_cnt` and `md_inflight`, which are registered.

## Timing
- Reset values: state IDLE, `cnt`=0, `stall_cnt`=0, `md_inflight`=0. With inputs idle, `md_start`=0, `md_stall`=0, `md_op`=111.
- The start cycle itself does not stall. The issuing instruction advances, and `md_stall` is asserted on the next `MULT_LAT`/`DIV_LAT` cycles if a dependent md instruction is in E.
- Back-to-back issue: a second mult/div is accepted in the first cycle after RUN exits, provided `md_busy`=0.
- Flush in the same cycle as a would-be start: no start, no state change, `md_op`=111, no stall counted.
- Flush while in RUN: RUN continues. The unit cannot be aborted, and HI/LO will be overwritten as the ISA allows.
- `reset` mid-RUN: the controller returns to IDLE next cycle. If the unit is still busy, the `md_busy` term keeps later md instructions stalled until it clears.
- `e_valid`=0 never stalls, even in RUN. Non-md instructions flow freely past an in-flight operation.

## Test plan
- mult then mfhi: mult in E at cycle 0 gives `md_start`=1 and `md_op`=000. mfhi in E at cycle 1 gives `md_stall`=1 for cycles 1–5. At cycle 6 it gives `md_stall`=0, `md_op`=110, and `stall_cnt`=5.
- divu then mflo with `DIV_LAT`=10: `md_start` at cycle 0, stall for cycles 1–10, release at cycle 11 with `stall_cnt`=10.
- mthi while RUN: `md_op` holds 111 (no HI write) until RUN ends, then drives 100 for exactly one cycle.
- Flush on a div at cycle 0: `md_start`=0, state remains IDLE, and a following mflo at cycle 1 does not stall.
- `reset` asserted at cycle 3 of a mult while `md_busy` is forced to 1 until cycle 4: all outputs return to their reset values at cycle 4. mflo stalls through cycle 4 and releases at cycle 5.
- `stall_cnt` preloaded to 0xFFFFFFFF via force, plus one stall cycle: the counter reads 0x00000000.
